chunked_serial_adder: RTL and testbench

Parametrised multi-cycle ripple-carry adder that adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock. The carry is held in a register between chunks. It trades latency for area in the arithmetic datapath. Operands are accepted on a valid/ready handshake, and results are returned on a second valid/ready handshake with back-pressure. It is the sequential, width-generic successor to the single-bit combinational adder cells, intended for 16/32/64-bit adder experiments.

---
 rtl/chunked_serial_adder.sv | 149 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle ripple-carry adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock,
// with valid/ready handshakes on both the operand and result sides.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  int               off_s;
  logic [CHUNK-1:0] a_sl_s, b_sl_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic             msb_cin_s;

  // Current chunk add; carry into the MSB is recovered from sum ^ a ^ b at the chunk's top bit
  always_comb begin
    off_s       = CHUNK * int'(idx_q);
    a_sl_s      = a_q[off_s +: CHUNK];
    b_sl_s      = b_q[off_s +: CHUNK];
    chunk_sum_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{CHUNK{1'b0}}, carry_q};
    msb_cin_s   = chunk_sum_s[CHUNK-1] ^ a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1];
  end

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_BUSY; else state_d = S_IDLE;
      S_BUSY:  if (idx_q == LAST_IDX) state_d = S_DONE; else state_d = S_BUSY;
      S_DONE:  if (out_ready) state_d = S_IDLE; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch on accept, ripple one chunk per BUSY cycle, publish on the last
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q;
        end
      end
      S_BUSY: begin
        res_d[off_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        carry_d               = chunk_sum_s[CHUNK];
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          sum_d  = res_d;
          cout_d = chunk_sum_s[CHUNK];
          ovf_d  = msb_cin_s ^ chunk_sum_s[CHUNK];
        end else begin
          idx_d  = idx_q + IDXW'(1);
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: four instances (16/4, 16/1, 16/16, 32/8)
// share operand and handshake inputs; each has its own expected-result queue.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;

  logic        ir_w [4];
  logic        ov_w [4];
  logic        co_w [4];
  logic        of_w [4];
  logic [15:0] sm16 [3];
  logic [31:0] sm32;

  int checks = 0;
  int passed = 0;

  logic [33:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[0]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .out_valid(ov_w[0]), .out_ready(out_ready), .sum(sm16[0]), .cout(co_w[0]),
    .overflow(of_w[0]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[1]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .out_valid(ov_w[1]), .out_ready(out_ready), .sum(sm16[1]), .cout(co_w[1]),
    .overflow(of_w[1]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[2]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .out_valid(ov_w[2]), .out_ready(out_ready), .sum(sm16[2]), .cout(co_w[2]),
    .overflow(of_w[2]));
  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[3]), .a(a), .b(b),
    .cin(cin), .out_valid(ov_w[3]), .out_ready(out_ready), .sum(sm32), .cout(co_w[3]),
    .overflow(of_w[3]));

  function automatic int nch(input int k);
    case (k)
      0: return 4;
      1: return 16;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int k);
    case (k)
      0: return {16'h0, sm16[0]};
      1: return {16'h0, sm16[1]};
      2: return {16'h0, sm16[2]};
      default: return sm32;
    endcase
  endfunction

  // Reference: {overflow, cout, sum} of a+b+cin at the instance's width
  function automatic logic [33:0] model(input int k, input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv);
    logic [16:0] s17;
    logic [32:0] s33;
    logic        ovf;
    if (k == 3) begin
      s33 = {1'b0, av} + {1'b0, bv} + {32'h0, cv};
      ovf = (av[31] == bv[31]) && (s33[31] != av[31]);
      return {ovf, s33[32], s33[31:0]};
    end else begin
      s17 = {1'b0, av[15:0]} + {1'b0, bv[15:0]} + {16'h0, cv};
      ovf = (av[15] == bv[15]) && (s17[15] != av[15]);
      return {ovf, s17[16], 16'h0, s17[15:0]};
    end
  endfunction

  function automatic logic [33:0] observed(input int k);
    return {of_w[k], co_w[k], get_sum(k)};
  endfunction

  task automatic push(input int k, input logic [33:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic pop(input int k, output logic [33:0] v);
    v = 34'h0;
    case (k)
      0: if (q0.size() > 0) v = q0.pop_front();
      1: if (q1.size() > 0) v = q1.pop_front();
      2: if (q2.size() > 0) v = q2.pop_front();
      default: if (q3.size() > 0) v = q3.pop_front();
    endcase
  endtask

  task automatic wait_all_idle();
    int n = 0;
    @(negedge clk);
    while (!(ir_w[0] && ir_w[1] && ir_w[2] && ir_w[3]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(ir_w[0] && ir_w[1] && ir_w[2] && ir_w[3]))
      $display("FAIL idle_wait: in_ready=%b%b%b%b after %0d cycles, want 1111",
               ir_w[0], ir_w[1], ir_w[2], ir_w[3], n);
    else passed++;
  endtask

  // One operation on all instances: push expectations, accept, then pop/compare each result
  task automatic run_all(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    logic        seen [4];
    logic [33:0] e;
    int          n;
    wait_all_idle();
    for (int k = 0; k < 4; k++) begin
      push(k, model(k, av, bv, cv));
      seen[k] = 1'b0;
    end
    out_ready = 1'b1;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && !(seen[0] && seen[1] && seen[2] && seen[3])) begin
      for (int k = 0; k < 4; k++) begin
        if (!seen[k] && ov_w[k]) begin
          seen[k] = 1'b1;
          pop(k, e);
          checks++;
          if (observed(k) !== e)
            $display("FAIL result[%0d] a=%h b=%h cin=%b: got %h want %h", k, av, bv, cv,
                     observed(k), e);
          else passed++;
          checks++;
          if (n != nch(k)) $display("FAIL latency[%0d]: got %0d want %0d", k, n, nch(k));
          else passed++;
        end
      end
      if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (!seen[k]) begin
        checks++;
        $display("FAIL timeout[%0d]: out_valid=0 after %0d cycles, want 1", k, n);
        pop(k, e);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ir_w[k], ov_w[k], observed(k)} !== {1'b1, 1'b0, 34'h0})
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b res=%h want 1 0 0", k, ir_w[k],
                 ov_w[k], observed(k));
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({ov_w[0], ov_w[1], ov_w[2], ov_w[3]} !== 4'b0000)
        $display("FAIL idle_no_valid: out_valid=%b%b%b%b want 0000", ov_w[0], ov_w[1], ov_w[2],
                 ov_w[3]);
      else passed++;
    end
  endtask

  task automatic test_basic();
    run_all(32'h0000_1234, 32'h0000_4321, 1'b0);
  endtask

  task automatic test_carry();
    run_all(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_all(32'h0000_7FFF, 32'h0000_0000, 1'b1);
    run_all(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    run_all(32'h8000_8000, 32'h8000_8000, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [33:0] e;
    logic        got = 1'b0;
    wait_all_idle();
    out_ready = 1'b0;
    push(0, model(0, 32'h0000_ABCD, 32'h0000_1357, 1'b1));
    a = 32'h0000_ABCD; b = 32'h0000_1357; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (ov_w[0]) got = 1'b1;
      else begin
        a = $urandom; b = $urandom; cin = ~cin;
        @(negedge clk);
      end
    end
    pop(0, e);
    checks++;
    if (!got) $display("FAIL bp_timeout: out_valid=0, want 1");
    else if (observed(0) !== e) $display("FAIL bp_result: got %h want %h", observed(0), e);
    else passed++;
    repeat (5) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      checks++;
      if ({ov_w[0], ir_w[0], observed(0)} !== {1'b1, 1'b0, e})
        $display("FAIL bp_hold: out_valid=%b in_ready=%b res=%h want 1 0 %h", ov_w[0], ir_w[0],
                 observed(0), e);
      else passed++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov_w[0], ir_w[0]} !== 2'b01)
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", ov_w[0], ir_w[0]);
    else passed++;
  endtask

  // in_valid held high: results every NCHUNK+2 cycles on the 16/4 instance
  task automatic test_back_to_back();
    int          hits[$];
    logic [33:0] e;
    wait_all_idle();
    e = model(0, 32'h0000_1111, 32'h0000_2222, 1'b1);
    a = 32'h0000_1111; b = 32'h0000_2222; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov_w[0]) begin
        hits.push_back(i);
        checks++;
        if (observed(0) !== e) $display("FAIL b2b_result: got %h want %h", observed(0), e);
        else passed++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (hits.size() < 5) $display("FAIL b2b_count: got %0d want >=5", hits.size());
    else passed++;
    for (int i = 1; i < hits.size(); i++) begin
      checks++;
      if (hits[i] - hits[i-1] != 6)
        $display("FAIL b2b_period: got %0d want 6", hits[i] - hits[i-1]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    wait_all_idle();
    a = 32'h0000_8000; b = 32'h0000_8000; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ir_w[0], ov_w[0], observed(0)} !== {1'b1, 1'b0, 34'h0})
      $display("FAIL reset_mid: in_ready=%b out_valid=%b res=%h want 1 0 0", ir_w[0], ov_w[0],
               observed(0));
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_all(32'h0000_0003, 32'h0000_0004, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_all($urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
